// File: rtl/arp_reply_receiver_if.sv
// arp_reply_receiver_if
// Receive byte stream plus the host-side request/result signals of the
// ARP reply receiver. The master side feeds bytes and requests; the slave
// side (the receiver) returns status and the resolved address pair.
interface arp_reply_receiver_if;
  logic        DATA_VALID_RX;
  logic [7:0]  DATA_RX;
  logic        REQ_VALID;
  logic [31:0] REQ_IP;
  logic        CANCEL;
  logic        BUSY;
  logic        RESOLVED;
  logic [47:0] RESOLVED_MAC;
  logic [31:0] RESOLVED_IP;
  logic        TIMEOUT;

  modport master (
    output DATA_VALID_RX, DATA_RX, REQ_VALID, REQ_IP, CANCEL,
    input  BUSY, RESOLVED, RESOLVED_MAC, RESOLVED_IP, TIMEOUT
  );

  modport slave (
    input  DATA_VALID_RX, DATA_RX, REQ_VALID, REQ_IP, CANCEL,
    output BUSY, RESOLVED, RESOLVED_MAC, RESOLVED_IP, TIMEOUT
  );
endinterface

// File: rtl/arp_reply_receiver.sv
// arp_reply_receiver
// Receive-side ARP initiator. Once armed with a target IPv4 address it
// watches the CLK_RX byte stream for an ARP reply from that address aimed
// at MY_MAC/MY_IPV4 and reports the sender MAC.
// Optional wait timeout is compiled in with macro ARP_REPLY_TIMEOUT_EN.
// Acceptance is decided on the edge that samples byte 41 (so it beats a
// same-edge CANCEL or timer expiry); results appear one edge later.
module arp_reply_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 125000000,
  parameter int unsigned TIMEOUT_W      = 27
) (
  input  logic                ARESET,
  input  logic                CLK_RX,
  input  logic [47:0]         MY_MAC,
  input  logic [31:0]         MY_IPV4,
  arp_reply_receiver_if.slave bus
);

  localparam logic [5:0] LAST_BYTE = 6'd41;
  localparam logic [5:0] CNT_MAX   = 6'd42;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic        mismatch_reg;
  logic        resync_reg;
  logic [47:0] sha_hold_reg;
  logic [31:0] spa_hold_reg;
  logic [31:0] target_reg;
  logic [47:0] resolved_mac_reg;
  logic [31:0] resolved_ip_reg;
  logic        resolved_reg;

  logic        check_en;
  logic [7:0]  exp_byte;
  logic        in_frame;
  logic        byte_bad;
  logic        frame_ok;
  logic        timer_expired;
  logic        load_result;
  logic        latch_target;
  logic        timeout_fire;

  // Big-endian byte views of the addresses compared against the stream
  logic [7:0] my_mac_b [6];
  logic [7:0] my_ip_b  [4];
  logic [7:0] target_b [4];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_mac_bytes
      assign my_mac_b[gi] = MY_MAC[47-8*gi -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_ip_bytes
      assign my_ip_b[gi]  = MY_IPV4[31-8*gi -: 8];
      assign target_b[gi] = target_reg[31-8*gi -: 8];
    end
  endgenerate

  // Expected value for the byte at the current position, if it is checked
  always_comb begin
    check_en = 1'b1;
    exp_byte = 8'h00;
    case (cnt_reg) inside
      [6'd0:6'd5]:   exp_byte = my_mac_b[3'(cnt_reg)];
      6'd12:         exp_byte = 8'h08;
      6'd13:         exp_byte = 8'h06;
      6'd14:         exp_byte = 8'h00;
      6'd15:         exp_byte = 8'h01;
      6'd16:         exp_byte = 8'h08;
      6'd17:         exp_byte = 8'h00;
      6'd18:         exp_byte = 8'h06;
      6'd19:         exp_byte = 8'h04;
      6'd20:         exp_byte = 8'h00;
      6'd21:         exp_byte = 8'h02;
      [6'd28:6'd31]: exp_byte = target_b[2'(cnt_reg - 6'd28)];
      [6'd32:6'd37]: exp_byte = my_mac_b[3'(cnt_reg - 6'd32)];
      [6'd38:6'd41]: exp_byte = my_ip_b[2'(cnt_reg - 6'd38)];
      default:       check_en = 1'b0;
    endcase
  end

  assign in_frame = bus.DATA_VALID_RX && (cnt_reg != CNT_MAX);
  assign byte_bad = in_frame && check_en && (bus.DATA_RX != exp_byte);
  // Byte 41 arriving now completes a frame that matched at every position
  assign frame_ok = bus.DATA_VALID_RX && (cnt_reg == LAST_BYTE) &&
                    !mismatch_reg && !resync_reg && !byte_bad;

  // Byte position counter and sticky mismatch; a gap in DATA_VALID_RX
  // restarts parsing. After reset the rest of an interrupted frame is
  // ignored until the stream goes idle.
  always_ff @(posedge CLK_RX or posedge ARESET) begin
    if (ARESET) begin
      cnt_reg      <= 6'd0;
      mismatch_reg <= 1'b0;
      resync_reg   <= 1'b1;
    end else if (!bus.DATA_VALID_RX) begin
      cnt_reg      <= 6'd0;
      mismatch_reg <= 1'b0;
      resync_reg   <= 1'b0;
    end else begin
      if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 6'd1;
      end
      if (byte_bad) begin
        mismatch_reg <= 1'b1;
      end
    end
  end

  // Shift sender hardware/protocol address bytes into holding registers
  always_ff @(posedge CLK_RX or posedge ARESET) begin
    if (ARESET) begin
      sha_hold_reg <= 48'd0;
      spa_hold_reg <= 32'd0;
    end else if (bus.DATA_VALID_RX) begin
      if (cnt_reg >= 6'd22 && cnt_reg <= 6'd27) begin
        sha_hold_reg <= {sha_hold_reg[39:0], bus.DATA_RX};
      end
      if (cnt_reg >= 6'd28 && cnt_reg <= 6'd31) begin
        spa_hold_reg <= {spa_hold_reg[23:0], bus.DATA_RX};
      end
    end
  end

`ifdef ARP_REPLY_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] timer_reg;
  logic                 timeout_reg;

  assign timer_expired = (state_reg == ST_WAIT) && (timer_reg == TIMER_LAST);

  // Wait timer: held at zero outside WAIT, counts every WAIT cycle
  always_ff @(posedge CLK_RX or posedge ARESET) begin
    if (ARESET) begin
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_fire;
      if (state_reg != ST_WAIT) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

  assign bus.TIMEOUT = timeout_reg;
`else
  assign timer_expired = 1'b0;
  assign bus.TIMEOUT   = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_W, timeout_fire};
`endif

  // Control FSM next state: acceptance beats CANCEL beats timer expiry
  always_comb begin
    state_next   = state_reg;
    load_result  = 1'b0;
    latch_target = 1'b0;
    timeout_fire = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          latch_target = 1'b1;
          state_next   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (frame_ok) begin
          state_next = ST_DONE;
        end else if (bus.CANCEL) begin
          state_next = ST_IDLE;
        end else if (timer_expired) begin
          timeout_fire = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_DONE: begin
        load_result = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control FSM state, latched target and registered results
  always_ff @(posedge CLK_RX or posedge ARESET) begin
    if (ARESET) begin
      state_reg        <= ST_IDLE;
      target_reg       <= 32'd0;
      resolved_reg     <= 1'b0;
      resolved_mac_reg <= 48'd0;
      resolved_ip_reg  <= 32'd0;
    end else begin
      state_reg    <= state_next;
      resolved_reg <= load_result;
      if (latch_target) begin
        target_reg <= bus.REQ_IP;
      end
      if (load_result) begin
        resolved_mac_reg <= sha_hold_reg;
        resolved_ip_reg  <= spa_hold_reg;
      end
    end
  end

  assign bus.BUSY         = (state_reg != ST_IDLE);
  assign bus.RESOLVED     = resolved_reg;
  assign bus.RESOLVED_MAC = resolved_mac_reg;
  assign bus.RESOLVED_IP  = resolved_ip_reg;

endmodule

// File: tb/tb_arp_reply_receiver.sv
// tb_arp_reply_receiver
// Table of reply variants, hand-written corner sequences (busy re-request,
// truncated frame, same-edge request/cancel/timeout, reset mid-frame) and
// randomized frames checked against a frame-level reference model.
// Timeout checks depend on macro ARP_REPLY_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_arp_reply_receiver;

  localparam int unsigned TO_CYCLES = 100;
  localparam logic [47:0] MY_MAC_C  = 48'h0A1B2C3D4E5F;
  localparam logic [31:0] MY_IP_C   = 32'hC0A8010A;
  localparam logic [31:0] TGT_IP    = 32'hC0A80114;
  localparam logic [31:0] TGT_IP2   = 32'hC0A80115;
  localparam logic [47:0] SHA_C     = 48'h021122334455;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_hdr_t;

  typedef struct {
    string       name;
    logic [47:0] dst;
    logic [15:0] etype;
    logic [15:0] oper;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          len;
    int          exp_res;
  } vec_t;

  logic CLK_RX = 1'b0;
  logic ARESET = 1'b1;
  logic [47:0] my_mac  = MY_MAC_C;
  logic [31:0] my_ipv4 = MY_IP_C;

  arp_reply_receiver_if bus ();

  arp_reply_receiver #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .TIMEOUT_W(8)
  ) dut (
    .ARESET(ARESET),
    .CLK_RX(CLK_RX),
    .MY_MAC(my_mac),
    .MY_IPV4(my_ipv4),
    .bus(bus)
  );

  always #5 CLK_RX = ~CLK_RX;

  int checks   = 0;
  int failures = 0;

  // Reference model state: armed flag, target, last accepted result
  bit          mdl_armed  = 1'b0;
  logic [31:0] mdl_target = 32'd0;
  logic [47:0] mdl_mac    = 48'd0;
  logic [31:0] mdl_ip     = 32'd0;

  logic [7:0] frame_b [64];
  vec_t       vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK_RX);
    #1;
  endtask

  function automatic arp_hdr_t good_hdr(input logic [47:0] sha, input logic [31:0] spa);
    arp_hdr_t h;
    h.dst   = MY_MAC_C;
    h.src   = sha;
    h.etype = 16'h0806;
    h.htype = 16'h0001;
    h.ptype = 16'h0800;
    h.hlen  = 8'd6;
    h.plen  = 8'd4;
    h.oper  = 16'h0002;
    h.sha   = sha;
    h.spa   = spa;
    h.tha   = MY_MAC_C;
    h.tpa   = MY_IP_C;
    return h;
  endfunction

  task automatic load_frame(input arp_hdr_t h);
    logic [335:0] v;
    v = h;
    for (int i = 0; i < 64; i++) begin
      if (i < 42) frame_b[i] = v[335-8*i -: 8];
      else        frame_b[i] = 8'($urandom);
    end
  endtask

  // Frame-level acceptance rule: reassemble the 42 header bytes and compare
  // every checked field with the values an acceptable reply must carry.
  function automatic bit model_frame_ok(input logic [31:0] target, output logic [47:0] sha,
                                        output logic [31:0] spa);
    logic [335:0] v;
    arp_hdr_t     p;
    for (int i = 0; i < 42; i++) v[335-8*i -: 8] = frame_b[i];
    p   = v;
    sha = p.sha;
    spa = p.spa;
    return (p.dst == MY_MAC_C) && (p.etype == 16'h0806) && (p.htype == 16'h0001) &&
           (p.ptype == 16'h0800) && (p.hlen == 8'd6) && (p.plen == 8'd4) &&
           (p.oper == 16'h0002) && (p.spa == target) && (p.tha == MY_MAC_C) &&
           (p.tpa == MY_IP_C);
  endfunction

  task automatic arm(input logic [31:0] ip);
    bus.REQ_VALID = 1'b1;
    bus.REQ_IP    = ip;
    cycle();
    bus.REQ_VALID = 1'b0;
    if (!mdl_armed) begin
      mdl_armed  = 1'b1;
      mdl_target = ip;
    end
    check("busy_after_req", 64'(bus.BUSY), 64'd1);
  endtask

  task automatic cancel_req();
    bus.CANCEL = 1'b1;
    cycle();
    bus.CANCEL = 1'b0;
    mdl_armed  = 1'b0;
    check("busy_after_cancel", 64'(bus.BUSY), 64'd0);
  endtask

  task automatic idle(input int n);
    bus.DATA_VALID_RX = 1'b0;
    bus.DATA_RX       = 8'h00;
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Stream frame_b[0..len-1] then three idle cycles; optional request and
  // cancel pulses at given byte positions. Checks against the model.
  task automatic send_and_check(input string tag, input int len, input int arm_at,
                                input logic [31:0] arm_ip, input int cancel_at,
                                output int got_res);
    int          res_pos;
    int          to_cnt;
    bit          acc;
    logic [47:0] m_sha;
    logic [31:0] m_spa;
    res_pos = -1;
    to_cnt  = 0;
    got_res = 0;
    acc     = 1'b0;
    for (int i = 0; i < len + 3; i++) begin
      bus.DATA_VALID_RX = (i < len);
      bus.DATA_RX       = (i < len) ? frame_b[i] : 8'h00;
      bus.REQ_VALID     = (i == arm_at);
      bus.REQ_IP        = arm_ip;
      bus.CANCEL        = (i == cancel_at);
      if (i == 41 && i < len && mdl_armed && model_frame_ok(mdl_target, m_sha, m_spa)) begin
        acc       = 1'b1;
        mdl_armed = 1'b0;
        mdl_mac   = m_sha;
        mdl_ip    = m_spa;
      end else if (mdl_armed && i == cancel_at) begin
        mdl_armed = 1'b0;
      end else if (!mdl_armed && i == arm_at) begin
        mdl_armed  = 1'b1;
        mdl_target = arm_ip;
      end
      cycle();
      if (bus.RESOLVED) begin
        got_res++;
        res_pos = i;
      end
      if (bus.TIMEOUT) to_cnt++;
    end
    bus.REQ_VALID = 1'b0;
    bus.CANCEL    = 1'b0;
    $display("frame %s len=%0d resolved=%0d busy=%0b mac=%012h", tag, len, got_res,
             bus.BUSY, bus.RESOLVED_MAC);
    check({tag, "_resolved_count"}, 64'(got_res), 64'(acc));
    if (acc) check({tag, "_resolved_pos"}, 64'(res_pos), 64'd42);
    check({tag, "_timeout"}, 64'(to_cnt), 64'd0);
    check({tag, "_busy"}, 64'(bus.BUSY), 64'(mdl_armed));
    check({tag, "_mac"}, 64'(bus.RESOLVED_MAC), 64'(mdl_mac));
    check({tag, "_ip"}, 64'(bus.RESOLVED_IP), 64'(mdl_ip));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    arp_hdr_t    h;
    int          got;
    int          first;
    int          pulses;
    int          len;
    int          k;
    bit          do_arm;
    int          cancel_at;
    logic [31:0] tgt;

    vecs[0] = '{"good60",     MY_MAC_C,        16'h0806, 16'h0002, TGT_IP,  MY_IP_C,        60, 1};
    vecs[1] = '{"oper_req",   MY_MAC_C,        16'h0806, 16'h0001, TGT_IP,  MY_IP_C,        60, 0};
    vecs[2] = '{"spa_other",  MY_MAC_C,        16'h0806, 16'h0002, TGT_IP2, MY_IP_C,        60, 0};
    vecs[3] = '{"dst_bcast",  48'hFFFFFFFFFFFF, 16'h0806, 16'h0002, TGT_IP,  MY_IP_C,        60, 0};
    vecs[4] = '{"etype_ipv4", MY_MAC_C,        16'h0800, 16'h0002, TGT_IP,  MY_IP_C,        60, 0};
    vecs[5] = '{"tpa_other",  MY_MAC_C,        16'h0806, 16'h0002, TGT_IP,  MY_IP_C ^ 32'h1, 60, 0};
    vecs[6] = '{"good42",     MY_MAC_C,        16'h0806, 16'h0002, TGT_IP,  MY_IP_C,        42, 1};
    vecs[7] = '{"short41",    MY_MAC_C,        16'h0806, 16'h0002, TGT_IP,  MY_IP_C,        41, 0};

    bus.DATA_VALID_RX = 1'b0;
    bus.DATA_RX       = 8'h00;
    bus.REQ_VALID     = 1'b0;
    bus.REQ_IP        = 32'd0;
    bus.CANCEL        = 1'b0;

    // Reset state
    cycle();
    cycle();
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_resolved", 64'(bus.RESOLVED), 64'd0);
    check("rst_timeout", 64'(bus.TIMEOUT), 64'd0);
    check("rst_mac", 64'(bus.RESOLVED_MAC), 64'd0);
    check("rst_ip", 64'(bus.RESOLVED_IP), 64'd0);
    ARESET = 1'b0;
    cycle();

    // Table of reply variants, each armed fresh
    for (int v = 0; v < 8; v++) begin
      h       = good_hdr(SHA_C + 48'(v), TGT_IP);
      h.dst   = vecs[v].dst;
      h.etype = vecs[v].etype;
      h.oper  = vecs[v].oper;
      h.spa   = vecs[v].spa;
      h.tpa   = vecs[v].tpa;
      load_frame(h);
      arm(TGT_IP);
      send_and_check(vecs[v].name, vecs[v].len, -1, 32'd0, -1, got);
      check({vecs[v].name, "_table"}, 64'(got), 64'(vecs[v].exp_res));
      if (mdl_armed) cancel_req();
      idle(1);
    end

    // Request while busy is ignored: target stays the first address
    arm(TGT_IP);
    arm(TGT_IP2);
    load_frame(good_hdr(48'h0200000000A1, TGT_IP));
    send_and_check("req_while_busy", 60, -1, 32'd0, -1, got);
    check("req_while_busy_res", 64'(got), 64'd1);

    // Truncated frame after byte 30, then a full reply
    arm(TGT_IP);
    load_frame(good_hdr(48'h0200000000B2, TGT_IP));
    send_and_check("truncated31", 31, -1, 32'd0, -1, got);
    send_and_check("after_trunc", 60, -1, 32'd0, -1, got);
    check("after_trunc_res", 64'(got), 64'd1);

    // Request on the same edge as byte 41: stays armed, no acceptance
    load_frame(good_hdr(48'h0200000000C3, TGT_IP));
    send_and_check("req_at_41", 60, 41, TGT_IP, -1, got);
    check("req_at_41_res", 64'(got), 64'd0);
    if (mdl_armed) cancel_req();

    // Cancel on the same edge as byte 41: acceptance wins
    arm(TGT_IP);
    load_frame(good_hdr(48'h0200000000D4, TGT_IP));
    send_and_check("cancel_at_41", 60, -1, 32'd0, 41, got);
    check("cancel_at_41_res", 64'(got), 64'd1);

    // Cancel mid-frame: no result, previous result retained
    arm(TGT_IP);
    load_frame(good_hdr(48'h0200000000E5, TGT_IP));
    send_and_check("cancel_at_20", 60, -1, 32'd0, 20, got);

    // Wait with no traffic
    arm(TGT_IP);
    first  = -1;
    pulses = 0;
    for (int c = 1; c <= 150; c++) begin
      cycle();
      if (bus.TIMEOUT) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
`ifdef ARP_REPLY_TIMEOUT_EN
    mdl_armed = 1'b0;
    check("timeout_latency", 64'(first), 64'(TO_CYCLES));
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_busy", 64'(bus.BUSY), 64'd0);
`else
    check("no_timeout_pulses", 64'(pulses), 64'd0);
    check("no_timeout_busy", 64'(bus.BUSY), 64'd1);
    cancel_req();
`endif
    check("timeout_mac_kept", 64'(bus.RESOLVED_MAC), 64'(mdl_mac));
    $display("wait first_timeout=%0d pulses=%0d", first, pulses);

    // Byte 41 lands on the final timeout edge: acceptance wins
    arm(TGT_IP);
    idle(58);
    load_frame(good_hdr(48'h0200000000F6, TGT_IP));
    send_and_check("accept_vs_timeout", 60, -1, 32'd0, -1, got);
    check("accept_vs_timeout_res", 64'(got), 64'd1);

    // Reset at byte 25 of a valid reply while armed
    arm(TGT_IP);
    load_frame(good_hdr(48'h020000000107, TGT_IP));
    for (int i = 0; i <= 25; i++) begin
      bus.DATA_VALID_RX = 1'b1;
      bus.DATA_RX       = frame_b[i];
      cycle();
    end
    ARESET = 1'b1;
    #1;
    check("arst_busy", 64'(bus.BUSY), 64'd0);
    check("arst_resolved", 64'(bus.RESOLVED), 64'd0);
    check("arst_timeout", 64'(bus.TIMEOUT), 64'd0);
    check("arst_mac", 64'(bus.RESOLVED_MAC), 64'd0);
    check("arst_ip", 64'(bus.RESOLVED_IP), 64'd0);
    mdl_armed  = 1'b0;
    mdl_target = 32'd0;
    mdl_mac    = 48'd0;
    mdl_ip     = 32'd0;
    pulses     = 0;
    for (int i = 26; i < 63; i++) begin
      bus.DATA_VALID_RX = (i < 60);
      bus.DATA_RX       = (i < 60) ? frame_b[i] : 8'h00;
      cycle();
      if (i == 26) ARESET = 1'b0;
      if (bus.RESOLVED) pulses++;
    end
    check("arst_no_resolve", 64'(pulses), 64'd0);
    check("arst_busy_after", 64'(bus.BUSY), 64'd0);
    arm(TGT_IP);
    load_frame(good_hdr(48'h020000000218, TGT_IP));
    send_and_check("after_reset", 60, -1, 32'd0, -1, got);
    check("after_reset_res", 64'(got), 64'd1);

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      tgt = $urandom;
      h   = good_hdr({16'h0200, 32'($urandom)}, tgt);
      k   = $urandom_range(0, 14);
      case (k)
        0: h.dst   = ($urandom_range(0, 1) == 0) ? 48'hFFFFFFFFFFFF : (h.dst ^ 48'h1);
        1: h.etype = h.etype ^ 16'($urandom_range(1, 65535));
        2: h.htype = h.htype ^ 16'($urandom_range(1, 65535));
        3: h.ptype = h.ptype ^ 16'($urandom_range(1, 65535));
        4: h.hlen  = h.hlen ^ 8'($urandom_range(1, 255));
        5: h.plen  = h.plen ^ 8'($urandom_range(1, 255));
        6: h.oper  = h.oper ^ 16'($urandom_range(1, 65535));
        7: h.spa   = h.spa ^ 32'($urandom_range(1, 1000));
        8: h.tha   = h.tha ^ 48'($urandom_range(1, 1000));
        9: h.tpa   = h.tpa ^ 32'($urandom_range(1, 1000));
        default: ;
      endcase
      load_frame(h);
      len       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 45)) : 60;
      do_arm    = ($urandom_range(0, 4) != 0);
      cancel_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 50)) : -1;
      if (do_arm) arm(tgt);
      send_and_check($sformatf("rand%0d", it), len, -1, 32'd0, cancel_at, got);
      if (mdl_armed) cancel_req();
      idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arp_reply_receiver.md
# arp_reply_receiver

- Receive-side ARP initiator on the CLK_RX byte stream.
- After the host arms it with a target IPv4 address, it parses incoming Ethernet frames, recognises the ARP reply from that address, and returns the resolved MAC.
- Pairs with the existing ARP responder: that block answers requests aimed at MY_IPV4; this block consumes replies addressed to MY_MAC.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 125000000: CLK_RX cycles to wait for a reply before giving up; used only with timeout compiled in.
- TIMEOUT_W, default 27: timeout counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- ARESET  input  1  reset, asynchronous, active-high
- CLK_RX  input  1  receive clock; all logic in this domain
- MY_MAC  input  48  local MAC; quasi-static
- MY_IPV4  input  32  local IPv4; quasi-static
- DATA_VALID_RX  input  1  high for each valid byte; contiguous within a frame
- DATA_RX  input  8  frame byte; first byte is destination MAC[47:40], preamble/SFD already stripped
- REQ_VALID  input  1  one-cycle pulse; arm a resolution
- REQ_IP  input  32  target IPv4, sampled when REQ_VALID is accepted
- CANCEL  input  1  one-cycle pulse; abort the armed resolution
- BUSY  output  1  high while armed
- RESOLVED  output  1  one-cycle pulse on a successful reply
- RESOLVED_MAC  output  48  sender hardware address of the accepted reply
- RESOLVED_IP  output  32  sender protocol address of the accepted reply
- TIMEOUT  output  1  one-cycle pulse when the wait expires

## Operation
- Parser byte counter runs 0..42.
  - It increments on each DATA_VALID_RX byte and saturates at 42; bytes after 41 (padding, FCS) are ignored.
  - DATA_VALID_RX low resets the counter to 0 and clears the mismatch flag.
  - A frame that ends before byte 41 is discarded.
- Checks, big-endian byte order. Any failure sets a sticky mismatch flag for the rest of the frame.
  - bytes 0-5 == MY_MAC
  - bytes 12-13 == 0x0806
  - bytes 14-15 == 0x0001
  - bytes 16-17 == 0x0800
  - byte 18 == 6, byte 19 == 4
  - bytes 20-21 == 0x0002 (reply)
  - bytes 28-31 (SPA) == latched target IP
  - bytes 32-37 (THA) == MY_MAC
  - bytes 38-41 (TPA) == MY_IPV4
- Capture: bytes 22-27 (SHA) and 28-31 (SPA) are shifted into holding registers.
- Control FSM:
  - IDLE: REQ_VALID latches REQ_IP and goes to WAIT. BUSY=1 from the next cycle.
  - WAIT, frame completes byte 41 with no mismatch: load RESOLVED_MAC/RESOLVED_IP from the holding registers, pulse RESOLVED, go to IDLE.
  - WAIT, CANCEL: go to IDLE with no pulse.
  - WAIT, timer reaches TIMEOUT_CYCLES-1: pulse TIMEOUT, go to IDLE.
- Frames complete while in IDLE are parsed but never accepted.
- REQ_VALID while BUSY is ignored; the latched target is unchanged.
- RESOLVED_MAC/RESOLVED_IP hold their value until the next successful resolution; TIMEOUT and CANCEL do not clear them.

## Timing
- Reset values:
  - BUSY=0, RESOLVED=0, TIMEOUT=0, RESOLVED_MAC=0, RESOLVED_IP=0
  - FSM=IDLE, counter=0, mismatch=0, target=0
- REQ_VALID sampled at edge E: BUSY high after E.
- A reply whose byte 41 is sampled at edge E itself is not accepted, because the FSM is still IDLE at E.
- Byte 41 sampled at edge N: RESOLVED, RESOLVED_MAC, RESOLVED_IP update and BUSY falls at edge N+1. RESOLVED is high for exactly one cycle.
- Simultaneous events:
  - Acceptance and timeout expiry on the same edge: acceptance wins, no TIMEOUT pulse.
  - Acceptance and CANCEL on the same edge: acceptance wins.
  - CANCEL and timeout on the same edge: CANCEL wins, no pulse.
- Timer clears on entry to WAIT and counts every WAIT cycle. TIMEOUT fires TIMEOUT_CYCLES cycles after BUSY rises.
- ARESET mid-frame or mid-wait: immediate return to reset values. The partial frame is discarded; the parser resynchronises on the next DATA_VALID_RX rising edge.
- ARESET deassertion is synchronised to CLK_RX by the integrator; the block registers asynchronous assert only.

## Configuration
- ARP_REPLY_TIMEOUT_EN defined: timeout counter present, TIMEOUT behaves as above.
- ARP_REPLY_TIMEOUT_EN undefined: no counter, TIMEOUT tied 0, and WAIT exits only on acceptance, CANCEL or ARESET.

## Test plan
- Arm REQ_IP=192.168.1.20. Send a 60-byte reply with SHA=02:11:22:33:44:55, SPA=192.168.1.20, THA=MY_MAC, TPA=MY_IPV4. Expect: RESOLVED pulse one edge after byte 41, RESOLVED_MAC=0x021122334455, BUSY=0.
- Armed; send the same frame with OPER=0x0001, then with SPA=192.168.1.21, then with destination MAC ff:ff:ff:ff:ff:ff. Expect: no RESOLVED, BUSY stays 1.
- Armed; drop DATA_VALID_RX after byte 30, then send a valid reply. Expect: only the second frame resolves.
- With ARP_REPLY_TIMEOUT_EN and TIMEOUT_CYCLES=100: arm and send nothing. Expect: TIMEOUT pulse 100 cycles after BUSY rises, RESOLVED_MAC unchanged.
- Arrange for byte 41 of a valid reply and the final timeout cycle to land on the same edge. Expect: RESOLVED=1, TIMEOUT=0.
- Assert ARESET at byte 25 of a valid reply while armed. Expect: all outputs 0, no RESOLVED. Re-arm and send a new reply: it resolves normally.
